// File: rtl/reg_demux_32_pkg.sv
// reg_demux_32_pkg: shared sizes and state encodings for the 32-word write demux.
package reg_demux_32_pkg;

    localparam int DATA_W = 32;
    localparam int WORDS  = 32;
    localparam int ADDR_W = 5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Word 0 is hard-wired to zero, so the sweep starts at word 1.
    localparam logic [ADDR_W-1:0] SWEEP_FIRST = 5'd1;

endpackage

// File: rtl/reg_demux_32_decoder_32.sv
// decoder_32: combinational 5-to-32 one-hot decoder with a global enable.
module decoder_32
    import reg_demux_32_pkg::*;
(
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [31:0]       onehot_o
);

    always_comb onehot_o = en_i ? (32'd1 << addr_i) : '0;

endmodule

// File: rtl/reg_demux_32.sv
// reg_demux_32: steers one write word into one of DEPTH holding registers and
// supports a sequential clear sweep of words 1..DEPTH-1.
module reg_demux_32
    import reg_demux_32_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = WORDS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic                   clear_req,
    output logic                   busy,
    output logic                   clear_done,
    output logic                   wr_ack,
    output logic [WIDTH*DEPTH-1:0] q_all
);

    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_ack_q, clear_done_q, clear_done_d;
    logic              accept, last;
    logic [31:0]       wr_en, clr_en;
    logic              unused_dec;

    assign busy       = state_q == ST_CLEAR;
    assign wr_ready   = state_q == ST_IDLE && !clear_req;
    assign accept     = wr_valid && wr_ready;
    assign last       = cnt_q == SWEEP_LAST;
    assign wr_ack     = wr_ack_q;
    assign clear_done = clear_done_q;

    always_comb begin
        state_d      = busy ? (last ? ST_IDLE : ST_CLEAR) : (clear_req ? ST_CLEAR : ST_IDLE);
        cnt_d        = busy && !last ? cnt_q + 5'd1 : SWEEP_FIRST;
        clear_done_d = busy && last;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= SWEEP_FIRST;
            wr_ack_q     <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ack_q     <= accept;
            clear_done_q <= clear_done_d;
        end
    end

    decoder_32 u_wr_dec (
        .en_i     (accept),
        .addr_i   (wr_addr),
        .onehot_o (wr_en)
    );

    decoder_32 u_clr_dec (
        .en_i     (busy),
        .addr_i   (cnt_q),
        .onehot_o (clr_en)
    );

    // Word 0 has no storage, so its decode bits go nowhere.
    assign unused_dec = wr_en[0] ^ clr_en[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (i == 0) begin : g_zero
            assign q_all[0 +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] word_q;
            always_ff @(posedge clock) begin
                if (!reset_n || clr_en[i])
                    word_q <= '0;
                else if (wr_en[i])
                    word_q <= wr_data;
            end
            assign q_all[i*WIDTH +: WIDTH] = word_q;
        end
    end

endmodule
